// File: rtl/signal_half_align_if.sv
// rtl/signal_half_align_if.sv - signal/reference/calibration bundle for signal_half_align
//
// Signals (direction as seen from the design, modport slave):
//   signal_in    in   incoming single-bit signal, launched on the remote negedge
//   ref_in       in   posedge-domain reference to align to
//   delay_sel    in   manual delay, DELAY_W bits
//   delay_src    in   0: manual delay, 1: calibrated delay
//   cal_start    in   one-cycle calibration request
//   cal_busy     out  calibration in progress
//   cal_done     out  one-cycle pulse at calibration end
//   cal_error    out  last calibration failed (sticky until next accepted cal_start)
//   delay_cur    out  delay currently applied, DELAY_W bits
//   signal_out   out  aligned signal
//   signal_rise  out  one-cycle pulse with signal_out 0->1
//   signal_fall  out  one-cycle pulse with signal_out 1->0

interface signal_half_align_if #(
    parameter int DELAY_W = 4
);
    logic               signal_in;
    logic               ref_in;
    logic [DELAY_W-1:0] delay_sel;
    logic               delay_src;
    logic               cal_start;
    logic               cal_busy;
    logic               cal_done;
    logic               cal_error;
    logic [DELAY_W-1:0] delay_cur;
    logic               signal_out;
    logic               signal_rise;
    logic               signal_fall;

    modport master (
        output signal_in, ref_in, delay_sel, delay_src, cal_start,
        input  cal_busy, cal_done, cal_error, delay_cur,
               signal_out, signal_rise, signal_fall
    );

    modport slave (
        input  signal_in, ref_in, delay_sel, delay_src, cal_start,
        output cal_busy, cal_done, cal_error, delay_cur,
               signal_out, signal_rise, signal_fall
    );
endinterface

// File: rtl/signal_half_align.sv
// rtl/signal_half_align.sv - re-times a negedge-launched signal into the posedge domain with selectable delay
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous reset, active-high
//   bus   signal_half_align_if.slave (signal in/out, reference, delay control, calibration status)
//
// Build option:
//   SIGNAL_ALIGN_CAL_EN  when defined, includes the calibration FSM that measures the
//                        distance from the tap[0] rise to the ref_in rise. When undefined,
//                        cal_busy/cal_done/cal_error read 0, delay_src/cal_start/ref_in are
//                        ignored and delay_cur always follows the clamped delay_sel.

module signal_half_align #(
    parameter int MAX_DELAY   = 16,
    parameter int DELAY_W     = 4,
    parameter int CAL_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    signal_half_align_if.slave bus
);
    localparam logic [DELAY_W-1:0] DELAY_MAX = DELAY_W'(MAX_DELAY - 1);

    logic                 neg_cap;
    logic [MAX_DELAY-1:0] tap;
    logic [DELAY_W-1:0]   delay_cur;
    logic [DELAY_W-1:0]   delay_next;
    logic [DELAY_W-1:0]   delay_clamped;
    logic                 tap_sel;
    logic                 signal_out;
    logic                 signal_rise;
    logic                 signal_fall;
    logic                 cal_busy;
    logic                 cal_done;
    logic                 cal_error;

    // The remote side launches on its negedge, so sampling on our negedge
    // sits mid-eye for the incoming level.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_cap <= 1'b0;
        end else begin
            neg_cap <= bus.signal_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap <= '0;
        end else begin
            tap <= {tap[MAX_DELAY-2:0], neg_cap};
        end
    end

    assign delay_clamped = (bus.delay_sel > DELAY_MAX) ? DELAY_MAX : bus.delay_sel;

    // Explicit compare-mux keeps the select well defined when DELAY_W is
    // wider than the tap index.
    always_comb begin
        tap_sel = 1'b0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (delay_cur == DELAY_W'(i)) begin
                tap_sel = tap[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_cur   <= '0;
            signal_out  <= 1'b0;
            signal_rise <= 1'b0;
            signal_fall <= 1'b0;
        end else begin
            delay_cur   <= delay_next;
            signal_out  <= tap_sel;
            signal_rise <= tap_sel & ~signal_out;
            signal_fall <= ~tap_sel & signal_out;
        end
    end

`ifdef SIGNAL_ALIGN_CAL_EN
    typedef enum logic [1:0] {
        IDLE,
        WAIT_SIG,
        COUNT,
        FINISH
    } state_t;

    // One counter serves both the WAIT_SIG timeout and the COUNT distance.
    localparam int CNT_W = $clog2(CAL_TIMEOUT + MAX_DELAY + 2);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_DELAY);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(CAL_TIMEOUT - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               cal_error_next;
    logic [DELAY_W-1:0] cal_delay;
    logic [DELAY_W-1:0] cal_delay_next;
    logic               tap0_prev;
    logic               ref_prev;
    logic               tap0_rise;
    logic               ref_rise;

    assign tap0_rise = tap[0] & ~tap0_prev;
    assign ref_rise  = bus.ref_in & ~ref_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cal_error <= 1'b0;
            cal_delay <= '0;
            tap0_prev <= 1'b0;
            ref_prev  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cal_error <= cal_error_next;
            cal_delay <= cal_delay_next;
            tap0_prev <= tap[0];
            ref_prev  <= bus.ref_in;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        cal_error_next = cal_error;
        cal_delay_next = cal_delay;
        case (state)
            IDLE: begin
                if (bus.cal_start) begin
                    state_next     = WAIT_SIG;
                    cnt_next       = '0;
                    cal_error_next = 1'b0;
                end
            end
            WAIT_SIG: begin
                // A reference rise coinciding with the signal rise means the
                // signal would need a negative delay.
                if (tap0_rise && ref_rise) begin
                    state_next     = FINISH;
                    cal_error_next = 1'b1;
                end else if (tap0_rise) begin
                    state_next = COUNT;
                    cnt_next   = CNT_W'(1);
                end else if (cnt == CNT_TIMEOUT) begin
                    state_next     = FINISH;
                    cal_error_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            COUNT: begin
                if (cnt > CNT_MAX) begin
                    state_next     = FINISH;
                    cal_error_next = 1'b1;
                end else if (ref_rise) begin
                    state_next     = FINISH;
                    cal_delay_next = DELAY_W'(cnt - CNT_W'(1));
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cal_busy = (state != IDLE);
    assign cal_done = (state == FINISH);

    // Freeze the applied delay while a measurement is running so the
    // output path does not move underneath it.
    assign delay_next = cal_busy ? delay_cur
                                 : (bus.delay_src ? cal_delay : delay_clamped);
`else
    logic unused_cal_inputs;

    assign unused_cal_inputs = ^{bus.delay_src, bus.cal_start, bus.ref_in};
    assign cal_busy   = 1'b0;
    assign cal_done   = 1'b0;
    assign cal_error  = 1'b0;
    assign delay_next = delay_clamped;
`endif

    assign bus.cal_busy    = cal_busy;
    assign bus.cal_done    = cal_done;
    assign bus.cal_error   = cal_error;
    assign bus.delay_cur   = delay_cur;
    assign bus.signal_out  = signal_out;
    assign bus.signal_rise = signal_rise;
    assign bus.signal_fall = signal_fall;
endmodule
